hazard_controller: RTL and testbench
====================================

// Module: hazard_controller
// PURPOSE
//  Sequences the 5-stage pipeline (IF/ID/EX/MEM/WB): produces per-stage enables/flushes, detects load-use hazards,
//  squashes wrong-path work on branch/jump redirect (resolved in MEM), and registers the EX operand forwarding selects.
//  Also runs halt/drain/resume sequencing and the stall and flush performance counters.
// PARAMETERS
//  AW           5   register address width
//  CNT_W        32  stall/flush counter width
//  DRAIN_CYCLES 4   bubble cycles injected before entering HALTED
// PORTS
//  clk             in  1     pipeline clock
//  reset           in  1     asynchronous, active-low reset
//  id_rs, id_rt    in  AW    source registers of the instruction in ID
//  id_uses_rt      in  1     ID instruction reads rt as an operand
//  ex_reg_write    in  1     EX instruction writes the register file
//  ex_mem_read     in  1     EX instruction is a load (EX_MemToReg)
//  ex_wb_addr      in  AW    EX destination register (after the RegDst mux)
//  mem_reg_write   in  1     MEM instruction writes the register file
//  mem_wb_addr     in  AW    MEM destination register
//  mem_redirect    in  1     branch taken (Do_branch) or jump in MEM
//  mem_busy        in  1     data memory not ready: freeze the whole pipeline
//  halt_req, resume in 1     level requests from debug/test control
//  pc_en           out 1     PC load enable
//  if_id_en        out 1     IF/ID register enable
//  if_id_flush     out 1     load a bubble into IF/ID
//  id_ex_flush     out 1     load a bubble into ID/EX (all control bits 0)
//  ex_mem_flush    out 1     load a bubble into EX/MEM
//  pipe_en         out 1     enable for ID/EX, EX/MEM, MEM/WB
//  fwd_a, fwd_b    out 2     EX operand select: 00 regfile, 01 EX/MEM result, 10 MEM/WB write data
//  halted          out 1     FSM is in HALTED
//  stall_cnt       out CNT_W count of stall cycles
//  flush_cnt       out CNT_W count of redirect cycles
// BEHAVIOUR
//  Reset (async, reset==0): state=RUN; drain_cnt=0; fwd_a=fwd_b=00; counters=0. Outputs then take RUN idle values:
//   pc_en=if_id_en=pipe_en=1, all flushes 0, halted=0.
//  load_use = ex_mem_read & ex_wb_addr!=0 & (ex_wb_addr==id_rs | (id_uses_rt & ex_wb_addr==id_rt)).
//  Controls are combinational (Mealy); priority is freeze > redirect > load_use > drain/halt.
//  FREEZE (mem_busy): all enables 0, all flushes 0; FSM, drain_cnt and fwd regs hold; stall_cnt+1.
//  REDIRECT (mem_redirect, no freeze): pc_en=1 (target loads), if_id_flush=id_ex_flush=ex_mem_flush=1, pipe_en=1;
//   load_use is ignored; flush_cnt+1. Legal in RUN and DRAIN; in DRAIN, drain_cnt still decrements.
//  LOAD_USE (RUN or DRAIN, no freeze/redirect): pc_en=0, if_id_en=0, id_ex_flush=1, pipe_en=1; stall_cnt+1;
//   drain_cnt does not decrement. Exactly one bubble is inserted; the load reaches MEM and the hazard clears.
//  FSM:
//   RUN:    halt_req -> DRAIN, drain_cnt<=DRAIN_CYCLES-1.
//   DRAIN:  pc_en=0, if_id_flush=1, rest of pipeline advances; drain_cnt-1 per non-stalled cycle;
//           drain_cnt==0 -> HALTED. halt_req dropping in DRAIN does not abort.
//   HALTED: pc_en=if_id_en=pipe_en=0, flushes 0, halted=1; resume -> RUN. resume and halt_req together -> RUN.
//  Forwarding regs update on any edge where pipe_en=1 and no freeze:
//   if id_ex_flush -> 00;
//   else fwd_a = (ex_reg_write & ex_wb_addr!=0 & ex_wb_addr==id_rs) ? 01 :
//                (mem_reg_write & mem_wb_addr!=0 & mem_wb_addr==id_rs) ? 10 : 00.
//   fwd_b is the same computation on id_rt; it is 00 when id_uses_rt=0.
//   In all other cycles the forwarding regs hold. Register 0 is never forwarded.
//   The same-cycle WB->ID case is covered by regfile write-first and is not handled here.
//  Counters saturate at all-ones. Reset mid-DRAIN or mid-stall returns to RUN immediately.
// TESTING
//  1. ex_mem_read=1, ex_wb_addr=5, id_rs=5 -> 1 cycle pc_en=0, if_id_en=0, id_ex_flush=1, stall_cnt 0->1;
//     next cycle mem_wb_addr=5, mem_reg_write=1 -> at the edge fwd_a=10.
//  2. ex_reg_write=1, ex_wb_addr=3, id_rt=3, id_uses_rt=1 -> fwd_b=01 at the edge;
//     ex_wb_addr=0, id_rs=0 -> fwd_a=00.
//  3. mem_redirect=1 with load_use active -> three flushes=1, pc_en=1, flush_cnt+1, stall_cnt unchanged, fwd=00.
//  4. halt_req pulse in RUN -> 4 cycles pc_en=0, if_id_flush=1, then halted=1;
//     resume=1 -> RUN next cycle, pc_en=1.
//  5. mem_busy=1 for 3 cycles during load_use -> all enables/flushes 0, stall_cnt+3, fwd and state held;
//     the stall bubble is issued after release.
//  6. reset=0 asynchronously in DRAIN with counters nonzero -> immediately halted=0, counters 0, fwd 00, RUN.

Source files
------------

// File: rtl/hazard_controller_if.sv
// Pipeline-side hazard bus: hazard inputs from ID/EX/MEM and debug control,
// stage enables/flushes, forwarding selects and counters back to the datapath.
//   master: pipeline/datapath side (drives hazard inputs, consumes controls)
//   slave : hazard_controller side
interface hazard_controller_if #(
  parameter int unsigned AW    = 5,
  parameter int unsigned CNT_W = 32
);
  logic [AW-1:0]    id_rs;
  logic [AW-1:0]    id_rt;
  logic             id_uses_rt;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic [AW-1:0]    ex_wb_addr;
  logic             mem_reg_write;
  logic [AW-1:0]    mem_wb_addr;
  logic             mem_redirect;
  logic             mem_busy;
  logic             halt_req;
  logic             resume;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             pipe_en;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_reg_write, ex_mem_read, ex_wb_addr,
           mem_reg_write, mem_wb_addr, mem_redirect, mem_busy, halt_req, resume,
    input  pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush, pipe_en,
           fwd_a, fwd_b, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_reg_write, ex_mem_read, ex_wb_addr,
           mem_reg_write, mem_wb_addr, mem_redirect, mem_busy, halt_req, resume,
    output pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush, pipe_en,
           fwd_a, fwd_b, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_controller.sv
// Hazard controller for a 5-stage pipeline (IF/ID/EX/MEM/WB).
// Produces stage enables/flushes (combinational, Mealy), detects load-use
// hazards, squashes wrong-path work on MEM redirects, registers the EX
// forwarding selects, sequences halt/drain/resume and counts stall/flush cycles.
//   clk   : pipeline clock
//   reset : asynchronous, active-low reset
//   bus   : hazard_controller_if slave (hazard inputs in; controls, fwd, counters out)
module hazard_controller #(
  parameter int unsigned AW           = 5,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  hazard_controller_if.slave bus
);

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  state_t           state;
  logic [DW-1:0]    drain_cnt;
  logic [1:0]       fwd_a_q;
  logic [1:0]       fwd_b_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  logic       load_use;
  logic       active;
  logic       redirect_act;
  logic       hazard_act;
  logic [1:0] fwd_a_nxt;
  logic [1:0] fwd_b_nxt;

  logic pc_en_c, if_id_en_c, if_id_flush_c, id_ex_flush_c, ex_mem_flush_c, pipe_en_c;

  // Forwarding source for one operand; the nearer (EX) producer wins, r0 never forwards.
  function automatic logic [1:0] src_sel(input logic [AW-1:0] src,
                                         input logic          ex_w,
                                         input logic [AW-1:0] ex_a,
                                         input logic          mem_w,
                                         input logic [AW-1:0] mem_a);
    if (ex_w && (ex_a != '0) && (ex_a == src))
      return 2'b01;
    else if (mem_w && (mem_a != '0) && (mem_a == src))
      return 2'b10;
    else
      return 2'b00;
  endfunction

  // Saturating increment for the performance counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign load_use = bus.ex_mem_read && (bus.ex_wb_addr != '0) &&
                    ((bus.ex_wb_addr == bus.id_rs) ||
                     (bus.id_uses_rt && (bus.ex_wb_addr == bus.id_rt)));

  // Redirect and load-use only act on a live, unfrozen pipeline.
  assign active       = !bus.mem_busy && (state != S_HALTED);
  assign redirect_act = active && bus.mem_redirect;
  assign hazard_act   = active && !bus.mem_redirect && load_use;

  assign fwd_a_nxt = (redirect_act || hazard_act) ? 2'b00 :
                     src_sel(bus.id_rs, bus.ex_reg_write, bus.ex_wb_addr,
                             bus.mem_reg_write, bus.mem_wb_addr);
  assign fwd_b_nxt = (redirect_act || hazard_act || !bus.id_uses_rt) ? 2'b00 :
                     src_sel(bus.id_rt, bus.ex_reg_write, bus.ex_wb_addr,
                             bus.mem_reg_write, bus.mem_wb_addr);

  // Stage controls: freeze > redirect > load-use > drain/halt.
  always_comb begin
    pc_en_c        = 1'b0;
    if_id_en_c     = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_flush_c  = 1'b0;
    ex_mem_flush_c = 1'b0;
    pipe_en_c      = 1'b0;
    if (active) begin
      pipe_en_c = 1'b1;
      if (redirect_act) begin
        pc_en_c        = 1'b1;
        if_id_en_c     = 1'b1;
        if_id_flush_c  = 1'b1;
        id_ex_flush_c  = 1'b1;
        ex_mem_flush_c = 1'b1;
      end else if (hazard_act) begin
        id_ex_flush_c = 1'b1;
      end else if (state == S_DRAIN) begin
        if_id_en_c    = 1'b1;
        if_id_flush_c = 1'b1;
      end else begin
        pc_en_c    = 1'b1;
        if_id_en_c = 1'b1;
      end
    end
  end

  // FSM, drain counter, forwarding selects and performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_RUN;
      drain_cnt <= '0;
      fwd_a_q   <= 2'b00;
      fwd_b_q   <= 2'b00;
      stall_q   <= '0;
      flush_q   <= '0;
    end else if (bus.mem_busy) begin
      stall_q <= sat_inc(stall_q);
    end else begin
      unique case (state)
        S_RUN: begin
          if (bus.halt_req) begin
            state     <= S_DRAIN;
            drain_cnt <= DW'(DRAIN_CYCLES - 1);
          end
        end
        S_DRAIN: begin
          // A load-use stall does not consume a drain bubble.
          if (!hazard_act) begin
            if (drain_cnt == '0)
              state <= S_HALTED;
            else
              drain_cnt <= drain_cnt - DW'(1);
          end
        end
        S_HALTED: begin
          if (bus.resume)
            state <= S_RUN;
        end
        default: state <= S_RUN;
      endcase
      if (state != S_HALTED) begin
        fwd_a_q <= fwd_a_nxt;
        fwd_b_q <= fwd_b_nxt;
      end
      if (redirect_act)
        flush_q <= sat_inc(flush_q);
      if (hazard_act)
        stall_q <= sat_inc(stall_q);
    end
  end

  assign bus.pc_en        = pc_en_c;
  assign bus.if_id_en     = if_id_en_c;
  assign bus.if_id_flush  = if_id_flush_c;
  assign bus.id_ex_flush  = id_ex_flush_c;
  assign bus.ex_mem_flush = ex_mem_flush_c;
  assign bus.pipe_en      = pipe_en_c;
  assign bus.halted       = (state == S_HALTED);
  assign bus.fwd_a        = fwd_a_q;
  assign bus.fwd_b        = fwd_b_q;
  assign bus.stall_cnt    = stall_q;
  assign bus.flush_cnt    = flush_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios plus a
// randomized run checked against a cycle-level behavioural model.
module tb_hazard_controller;
  localparam int unsigned AW    = 5;
  localparam int unsigned CNT_W = 32;
  localparam int M_RUN = 0, M_DRAIN = 1, M_HALTED = 2;
  localparam longint MAXC = (64'd1 << CNT_W) - 1;

  // control vector order: pc_en if_id_en if_id_flush id_ex_flush ex_mem_flush pipe_en halted
  localparam logic [6:0] C_IDLE     = 7'b1100010;
  localparam logic [6:0] C_LOADUSE  = 7'b0001010;
  localparam logic [6:0] C_REDIRECT = 7'b1111110;
  localparam logic [6:0] C_DRAIN    = 7'b0110010;
  localparam logic [6:0] C_HALTED   = 7'b0000001;
  localparam logic [6:0] C_FROZEN   = 7'b0000000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_controller_if #(.AW(AW), .CNT_W(CNT_W)) bus ();

  hazard_controller #(.AW(AW), .CNT_W(CNT_W), .DRAIN_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int         m_mode;
  int         m_left;
  logic [1:0] m_fa, m_fb;
  longint     m_stall, m_flush;

  function automatic logic [6:0] dut_ctrl();
    return {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_flush,
            bus.ex_mem_flush, bus.pipe_en, bus.halted};
  endfunction

  // The load in EX writes a register the ID instruction reads.
  function automatic bit m_hazard();
    logic [AW-1:0] reads [$];
    reads.push_back(bus.id_rs);
    if (bus.id_uses_rt) reads.push_back(bus.id_rt);
    if (!bus.ex_mem_read || bus.ex_wb_addr == 0) return 1'b0;
    foreach (reads[i]) if (reads[i] == bus.ex_wb_addr) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] m_src(logic [AW-1:0] r, bit used);
    if (!used || r == 0) return 2'b00;
    if (bus.ex_reg_write && bus.ex_wb_addr == r) return 2'b01;
    if (bus.mem_reg_write && bus.mem_wb_addr == r) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [6:0] exp_ctrl();
    if (bus.mem_busy) return (m_mode == M_HALTED) ? C_HALTED : C_FROZEN;
    if (m_mode == M_HALTED) return C_HALTED;
    if (bus.mem_redirect) return C_REDIRECT;
    if (m_hazard()) return C_LOADUSE;
    if (m_mode == M_DRAIN) return C_DRAIN;
    return C_IDLE;
  endfunction

  task automatic model_reset();
    m_mode = M_RUN; m_left = 0; m_fa = 2'b00; m_fb = 2'b00; m_stall = 0; m_flush = 0;
  endtask

  // Advance model by one clock using the current inputs, then clock the DUT.
  task automatic tick();
    bit hz, rd;
    logic [1:0] na, nb;
    hz = m_hazard();
    rd = bus.mem_redirect;
    na = m_src(bus.id_rs, 1'b1);
    nb = m_src(bus.id_rt, bus.id_uses_rt);
    if (bus.mem_busy) begin
      if (m_stall < MAXC) m_stall++;
    end else if (m_mode == M_HALTED) begin
      if (bus.resume) m_mode = M_RUN;
    end else begin
      if (rd) begin
        if (m_flush < MAXC) m_flush++;
        m_fa = 2'b00; m_fb = 2'b00;
      end else if (hz) begin
        if (m_stall < MAXC) m_stall++;
        m_fa = 2'b00; m_fb = 2'b00;
      end else begin
        m_fa = na; m_fb = nb;
      end
      if (m_mode == M_RUN) begin
        if (bus.halt_req) begin m_mode = M_DRAIN; m_left = 3; end
      end else if (rd || !hz) begin
        if (m_left == 0) m_mode = M_HALTED; else m_left--;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rt = 1'b0;
    bus.ex_reg_write = 1'b0; bus.ex_mem_read = 1'b0; bus.ex_wb_addr = '0;
    bus.mem_reg_write = 1'b0; bus.mem_wb_addr = '0;
    bus.mem_redirect = 1'b0; bus.mem_busy = 1'b0;
    bus.halt_req = 1'b0; bus.resume = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_ctrl() !== C_IDLE) begin
      errors++; $display("FAIL reset_ctrl got %b exp %b", dut_ctrl(), C_IDLE);
    end
    checks++;
    if ({bus.fwd_a, bus.fwd_b, bus.stall_cnt, bus.flush_cnt} !== '0) begin
      errors++; $display("FAIL reset_regs got fwd %b%b stall %0d flush %0d exp all 0",
                         bus.fwd_a, bus.fwd_b, bus.stall_cnt, bus.flush_cnt);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_load_use();
    idle_inputs();
    bus.ex_mem_read = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_wb_addr = 5'd5; bus.id_rs = 5'd5;
    #1;
    checks++;
    if (dut_ctrl() !== C_LOADUSE) begin
      errors++; $display("FAIL load_use_ctrl got %b exp %b", dut_ctrl(), C_LOADUSE);
    end
    tick();
    checks++;
    if (bus.stall_cnt !== CNT_W'(1) || bus.fwd_a !== 2'b00) begin
      errors++; $display("FAIL load_use_stall got stall %0d fwd_a %b exp 1 00", bus.stall_cnt, bus.fwd_a);
    end
    // Load now in MEM; ID instruction picks up MEM/WB data.
    idle_inputs();
    bus.id_rs = 5'd5; bus.mem_reg_write = 1'b1; bus.mem_wb_addr = 5'd5;
    #1;
    checks++;
    if (dut_ctrl() !== C_IDLE) begin
      errors++; $display("FAIL load_use_clear got %b exp %b", dut_ctrl(), C_IDLE);
    end
    tick();
    checks++;
    if (bus.fwd_a !== 2'b10 || bus.stall_cnt !== CNT_W'(1)) begin
      errors++; $display("FAIL load_use_fwd got fwd_a %b stall %0d exp 10 1", bus.fwd_a, bus.stall_cnt);
    end
  endtask

  task automatic test_forwarding();
    idle_inputs();
    bus.ex_reg_write = 1'b1; bus.ex_wb_addr = 5'd3; bus.id_rt = 5'd3; bus.id_uses_rt = 1'b1;
    bus.id_rs = 5'd9; bus.mem_reg_write = 1'b1; bus.mem_wb_addr = 5'd9;
    tick();
    checks++;
    if (bus.fwd_a !== 2'b10 || bus.fwd_b !== 2'b01) begin
      errors++; $display("FAIL fwd_ex_mem got %b %b exp 10 01", bus.fwd_a, bus.fwd_b);
    end
    // Register 0 never forwards; id_uses_rt=0 kills fwd_b.
    bus.ex_wb_addr = 5'd0; bus.id_rs = 5'd0; bus.mem_wb_addr = 5'd0; bus.id_uses_rt = 1'b0;
    tick();
    checks++;
    if (bus.fwd_a !== 2'b00 || bus.fwd_b !== 2'b00) begin
      errors++; $display("FAIL fwd_r0 got %b %b exp 00 00", bus.fwd_a, bus.fwd_b);
    end
    // EX beats MEM when both write the same register.
    bus.ex_wb_addr = 5'd7; bus.mem_wb_addr = 5'd7; bus.id_rs = 5'd7;
    tick();
    checks++;
    if (bus.fwd_a !== 2'b01 || bus.fwd_a !== m_fa) begin
      errors++; $display("FAIL fwd_priority got %b exp 01", bus.fwd_a);
    end
  endtask

  task automatic test_redirect();
    int unsigned s0, f0;
    s0 = bus.stall_cnt; f0 = bus.flush_cnt;
    idle_inputs();
    bus.ex_mem_read = 1'b1; bus.ex_wb_addr = 5'd4; bus.id_rt = 5'd4; bus.id_uses_rt = 1'b1;
    bus.mem_redirect = 1'b1;
    #1;
    checks++;
    if (dut_ctrl() !== C_REDIRECT) begin
      errors++; $display("FAIL redirect_ctrl got %b exp %b", dut_ctrl(), C_REDIRECT);
    end
    tick();
    checks++;
    if (bus.flush_cnt !== CNT_W'(f0 + 1) || bus.stall_cnt !== CNT_W'(s0) ||
        bus.fwd_a !== 2'b00 || bus.fwd_b !== 2'b00) begin
      errors++; $display("FAIL redirect_regs got flush %0d stall %0d fwd %b%b exp %0d %0d 0000",
                         bus.flush_cnt, bus.stall_cnt, bus.fwd_a, bus.fwd_b, f0 + 1, s0);
    end
  endtask

  task automatic test_halt();
    idle_inputs();
    bus.halt_req = 1'b1;
    #1;
    checks++;
    if (dut_ctrl() !== C_IDLE) begin
      errors++; $display("FAIL halt_req_cycle got %b exp %b", dut_ctrl(), C_IDLE);
    end
    tick();
    bus.halt_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (dut_ctrl() !== C_DRAIN) begin
        errors++; $display("FAIL drain_%0d got %b exp %b", i, dut_ctrl(), C_DRAIN);
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dut_ctrl() !== C_HALTED) begin
        errors++; $display("FAIL halted_%0d got %b exp %b", i, dut_ctrl(), C_HALTED);
      end
      tick();
    end
    bus.resume = 1'b1; bus.halt_req = 1'b1;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (dut_ctrl() !== C_IDLE) begin
      errors++; $display("FAIL resume got %b exp %b", dut_ctrl(), C_IDLE);
    end
  endtask

  task automatic test_freeze();
    int unsigned s0;
    idle_inputs();
    bus.ex_reg_write = 1'b1; bus.ex_wb_addr = 5'd7; bus.id_rs = 5'd7;
    tick();
    s0 = bus.stall_cnt;
    bus.ex_mem_read = 1'b1; bus.mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (dut_ctrl() !== C_FROZEN) begin
        errors++; $display("FAIL freeze_ctrl_%0d got %b exp %b", i, dut_ctrl(), C_FROZEN);
      end
      tick();
    end
    checks++;
    if (bus.stall_cnt !== CNT_W'(s0 + 3) || bus.fwd_a !== 2'b01 || bus.halted !== 1'b0) begin
      errors++; $display("FAIL freeze_hold got stall %0d fwd_a %b exp %0d 01", bus.stall_cnt, bus.fwd_a, s0 + 3);
    end
    bus.mem_busy = 1'b0;
    #1;
    checks++;
    if (dut_ctrl() !== C_LOADUSE) begin
      errors++; $display("FAIL freeze_release got %b exp %b", dut_ctrl(), C_LOADUSE);
    end
    tick();
    checks++;
    if (bus.stall_cnt !== CNT_W'(s0 + 4) || bus.fwd_a !== 2'b00) begin
      errors++; $display("FAIL freeze_bubble got stall %0d fwd_a %b exp %0d 00", bus.stall_cnt, bus.fwd_a, s0 + 4);
    end
  endtask

  task automatic test_async_reset();
    idle_inputs();
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0; bus.ex_reg_write = 1'b1; bus.ex_wb_addr = 5'd2; bus.id_rs = 5'd2;
    tick();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.halted !== 1'b0 || bus.stall_cnt !== '0 || bus.flush_cnt !== '0 ||
        bus.fwd_a !== 2'b00 || bus.pc_en !== 1'b0 + 1'b1) begin
      errors++; $display("FAIL async_reset got halted %b stall %0d flush %0d fwd_a %b pc_en %b",
                         bus.halted, bus.stall_cnt, bus.flush_cnt, bus.fwd_a, bus.pc_en);
    end
    #2;
    reset = 1'b1;
    idle_inputs();
    tick();
    checks++;
    if (dut_ctrl() !== C_IDLE) begin
      errors++; $display("FAIL post_reset_run got %b exp %b", dut_ctrl(), C_IDLE);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      bus.id_rs         = AW'($urandom_range(0, 3));
      bus.id_rt         = AW'($urandom_range(0, 3));
      bus.id_uses_rt    = 1'($urandom_range(0, 1));
      bus.ex_reg_write  = 1'($urandom_range(0, 1));
      bus.ex_mem_read   = ($urandom_range(0, 2) == 0);
      bus.ex_wb_addr    = AW'($urandom_range(0, 3));
      bus.mem_reg_write = 1'($urandom_range(0, 1));
      bus.mem_wb_addr   = AW'($urandom_range(0, 3));
      bus.mem_redirect  = ($urandom_range(0, 9) == 0);
      bus.mem_busy      = ($urandom_range(0, 7) == 0);
      bus.halt_req      = ($urandom_range(0, 24) == 0);
      bus.resume        = ($urandom_range(0, 5) == 0);
      #1;
      checks++;
      if (dut_ctrl() !== exp_ctrl()) begin
        errors++; $display("FAIL rand_ctrl cyc %0d got %b exp %b", n, dut_ctrl(), exp_ctrl());
      end
      tick();
      checks++;
      if (bus.fwd_a !== m_fa || bus.fwd_b !== m_fb ||
          bus.stall_cnt !== CNT_W'(m_stall) || bus.flush_cnt !== CNT_W'(m_flush)) begin
        errors++; $display("FAIL rand_regs cyc %0d got fwd %b %b stall %0d flush %0d exp %b %b %0d %0d",
                           n, bus.fwd_a, bus.fwd_b, bus.stall_cnt, bus.flush_cnt,
                           m_fa, m_fb, m_stall, m_flush);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forwarding();
    test_redirect();
    test_halt();
    test_freeze();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
